// File: rtl/sdf_r2_stage_if.sv
// Sample/twiddle/result bundle for one radix-2 SDF stage.
// master drives samples and ROM twiddles; slave is the stage itself.
interface sdf_r2_stage_if #(
    parameter int DEPTH  = 16,
    parameter int DW_IN  = 8,
    parameter int WW     = 8,
    parameter int DW_OUT = 14
);
    localparam int AW = $clog2(DEPTH);

    logic                     in_valid;
    logic signed [DW_IN-1:0]  in_r;
    logic signed [DW_IN-1:0]  in_i;
    logic                     flush;
    logic signed [WW-1:0]     tw_r;
    logic signed [WW-1:0]     tw_i;
    logic [AW-1:0]            tw_idx;
    logic                     out_valid;
    logic signed [DW_OUT-1:0] out_r;
    logic signed [DW_OUT-1:0] out_i;

    modport master (
        output in_valid, in_r, in_i, flush, tw_r, tw_i,
        input  tw_idx, out_valid, out_r, out_i
    );

    modport slave (
        input  in_valid, in_r, in_i, flush, tw_r, tw_i,
        output tw_idx, out_valid, out_r, out_i
    );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage with its own delay line, phase control and rounding.
// Latency: result registered on the edge that accepts the sample (out_valid the following cycle).
// No backpressure: stalls via in_valid=0 freeze all state; flush drains the second half with zeros.
module sdf_r2_stage #(
    parameter int DEPTH   = 16,
    parameter int DW_IN   = 8,
    parameter int WW      = 8,
    parameter int TW_FRAC = 6,
    parameter int DW_OUT  = 14
) (
    input  logic          clk,
    input  logic          rst,
    sdf_r2_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = DW_IN + 1;
    localparam int SW = LW + TW_FRAC;
    localparam int MW = LW + WW;
    localparam int PW = MW + 2;
    localparam int XA = (SW > PW) ? SW : PW;
    localparam int XW = (XA > DW_OUT) ? XA : DW_OUT;

    typedef enum logic [1:0] {IDLE, WAITING, FIRST, SECOND} ph_t;

    ph_t                      ph, ph_nxt;
    logic [AW-1:0]            cnt;
    logic signed [LW-1:0]     line_r [DEPTH];
    logic signed [LW-1:0]     line_i [DEPTH];

    logic                     adv, flush_adv, wrap, produce;
    logic signed [LW-1:0]     a_r, a_i, b_r, b_i, sr_r, sr_i;
    logic signed [LW:0]       sum_r, sum_i, dif_r, dif_i;
    logic signed [SW-1:0]     sh_r, sh_i;
    logic signed [MW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0]     acc_r, acc_i;
    logic signed [DW_OUT-1:0] res_r, res_i;
    logic signed [DW_OUT-1:0] q_r, q_i;
    logic                     q_vld;

    function automatic logic signed [LW-1:0] sat_lw(input logic signed [LW:0] x);
        if (x[LW] == x[LW-1])
            return x[LW-1:0];
        return {x[LW], {(LW-1){~x[LW]}}};
    endfunction

    function automatic logic signed [DW_OUT-1:0] sat_out(input logic signed [XW-1:0] x);
        if ((&x[XW-1:DW_OUT-1]) || ~(|x[XW-1:DW_OUT-1]))
            return x[DW_OUT-1:0];
        return {x[XW-1], {(DW_OUT-1){~x[XW-1]}}};
    endfunction

    always_comb begin
        flush_adv = !bus.in_valid && bus.flush && (ph == SECOND);
        adv       = bus.in_valid || flush_adv;
        wrap      = (cnt == AW'(DEPTH - 1));
        produce   = adv && ((ph == FIRST) || (ph == SECOND));

        // a flush advance feeds zeros into the butterfly
        a_r = bus.in_valid ? {bus.in_r[DW_IN-1], bus.in_r} : '0;
        a_i = bus.in_valid ? {bus.in_i[DW_IN-1], bus.in_i} : '0;
        b_r = line_r[cnt];
        b_i = line_i[cnt];

        sum_r = {a_r[LW-1], a_r} + {b_r[LW-1], b_r};
        sum_i = {a_i[LW-1], a_i} + {b_i[LW-1], b_i};
        dif_r = {b_r[LW-1], b_r} - {a_r[LW-1], a_r};
        dif_i = {b_i[LW-1], b_i} - {a_i[LW-1], a_i};
        sh_r  = {sum_r, {(TW_FRAC-1){1'b0}}};
        sh_i  = {sum_i, {(TW_FRAC-1){1'b0}}};

        p_rr  = MW'(b_r) * MW'(bus.tw_r);
        p_ii  = MW'(b_i) * MW'(bus.tw_i);
        p_ri  = MW'(b_r) * MW'(bus.tw_i);
        p_ir  = MW'(b_i) * MW'(bus.tw_r);
        acc_r = (PW'(p_rr) - PW'(p_ii) + PW'(1)) >>> 1;
        acc_i = (PW'(p_ri) + PW'(p_ir) + PW'(1)) >>> 1;

        sr_r  = a_r;
        sr_i  = a_i;
        res_r = sat_out(XW'(acc_r));
        res_i = sat_out(XW'(acc_i));
        if (ph == FIRST) begin
            sr_r  = sat_lw(dif_r);
            sr_i  = sat_lw(dif_i);
            res_r = sat_out(XW'(sh_r));
            res_i = sat_out(XW'(sh_i));
        end
    end

    always_comb begin
        ph_nxt = ph;
        case (ph)
            IDLE:    if (adv)         ph_nxt = WAITING;
            WAITING: if (adv && wrap) ph_nxt = FIRST;
            FIRST:   if (adv && wrap) ph_nxt = SECOND;
            SECOND:  if (adv && wrap) ph_nxt = bus.in_valid ? FIRST : IDLE;
            default:                  ph_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ph <= IDLE;
        else
            ph <= ph_nxt;
    end

    // cnt addresses a circular buffer: the slot about to be overwritten holds the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            q_vld <= 1'b0;
            q_r   <= '0;
            q_i   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                line_r[k] <= '0;
                line_i[k] <= '0;
            end
        end else begin
            q_vld <= produce;
            if (produce) begin
                q_r <= res_r;
                q_i <= res_i;
            end
            if (adv) begin
                line_r[cnt] <= sr_r;
                line_i[cnt] <= sr_i;
                cnt         <= cnt + 1'b1;
            end
        end
    end

    assign bus.out_valid = q_vld;
    assign bus.out_r     = q_r;
    assign bus.out_i     = q_i;
    assign bus.tw_idx    = (ph == SECOND) ? cnt : '0;
endmodule
